timing_seq: RTL and testbench
=============================

Name: timing_seq

Overview:
- Parametrised timing-signal sequencer for the CPU control unit; next generation of the fixed 16-state T0..T15 generator.
- Holds a state counter of configurable depth and drives a registered one-hot timing bus T0..T(NSTATES-1) to the control decoder.
- Adds a runtime-programmable last state, synchronous end-of-instruction clear, direct state load and an instruction-cycle counter.
- Sits between the control decoder and the register-transfer control logic.

Parameters:
- NSTATES, 16, number of timing states; legal range 2..64.
- CW, 4, state-counter width; must satisfy 2^CW >= NSTATES.
- CYC_W, 16, width of the completed-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; the counter steps only when high.
- clr  in  1  synchronous end-of-instruction clear; forces T0.
- load  in  1  synchronous load of load_val into the counter.
- load_val  in  CW  target state for load.
- last_state  in  CW  final state before the natural wrap to T0.
- t_count  out  CW  current state number.
- t_onehot  out  NSTATES  registered one-hot timing signals; bit k = Tk.
- done  out  1  one-cycle pulse when an instruction cycle completes.
- load_err  out  1  one-cycle pulse when a load is rejected.
- cyc_cnt  out  CYC_W  count of completed instruction cycles.

Behaviour:
- Reset (reset=0, asynchronous): t_count=0, t_onehot=1 (T0 active), done=0, load_err=0, cyc_cnt=0. Release is synchronous to clk.
- Effective last state eff_last = min(last_state, NSTATES-1), evaluated every cycle.
- Per-edge priority is clr > load > en > hold.
- clr=1:
  - t_count becomes 0 and done=1.
  - load and en are ignored that cycle.
- load=1, clr=0:
  - If load_val < NSTATES, t_count becomes load_val and done=0.
  - Otherwise t_count holds and load_err=1 for one cycle.
  - en is ignored that cycle.
- en=1, clr=0, load=0:
  - If t_count >= eff_last, t_count becomes 0 and done=1. This covers last_state being lowered below the current count mid-run.
  - Otherwise t_count increments by 1.
- No clr, load or en: all state holds; done=0 and load_err=0.
- t_onehot is updated on the same edge as t_count, so t_onehot == (1 << t_count) always. Exactly one bit is set at all times, never zero, never multiple.
- cyc_cnt increments by 1 on every edge where done is asserted. It wraps modulo 2^CYC_W with no saturation.
- clr together with a natural wrap on the same edge counts as one completion: done=1 and cyc_cnt increments by 1, not 2.
- done and load_err are registered pulses, high for exactly one cycle per event; back-to-back events keep them high on consecutive cycles.
- Latency: every control input takes effect on t_count/t_onehot at the next rising edge, i.e. one cycle.
- Reset mid-sequence returns to T0 immediately, without waiting for a clock edge, and clears cyc_cnt.

Optional Feature:
- Macro: TIMING_STEP_EN.
- When defined, adds ports step_mode (in, 1) and step (in, 1) for single-step debug.
- With step_mode=1, the en path is replaced by a single-step pulse:
  - step is edge-detected internally with a registered previous value (reset value 0).
  - Each 0->1 transition of step advances the sequence by exactly one state, using the same wrap, done and cyc_cnt rules as en.
  - en is ignored while step_mode=1.
- clr and load keep priority over step.
- With step_mode=0, behaviour is identical to the macro-undefined build.
- Macro undefined: no extra ports; en alone advances the sequence.

Test Plan:
- Reset, then en=1 with last_state=15, NSTATES=16 -> t_count runs 0..15 then wraps to 0; done pulses once per 16 cycles; cyc_cnt=3 after 48 enabled cycles.
- en=1, last_state=13, clr asserted while t_count=13 -> exactly one done pulse; cyc_cnt +1; next t_count=0; t_onehot=0x0001.
- At t_count=6, set last_state=3 -> next edge t_count=0 with done=1. last_state=20 with NSTATES=16 -> wraps after 15.
- load=1, load_val=9, en=1 -> t_count=9, t_onehot=0x0200, done=0. load_val=17 with NSTATES=16 -> t_count holds, load_err=1 for one cycle. clr+load together -> t_count=0.
- Drive reset low mid-sequence at t_count=7 between clock edges -> t_count=0, t_onehot=1, cyc_cnt=0 immediately; cyc_cnt=2^CYC_W-1 plus one done -> cyc_cnt=0.
- TIMING_STEP_EN defined, step_mode=1, en=1 held, step held high 5 cycles, then toggled 3 times -> t_count advances exactly 1 then 3 (total 4); clearing step_mode resumes per-cycle advance.

Source files
------------

// File: rtl/timing_seq.sv
// timing_seq: parametrised one-hot timing-state sequencer with programmable last state,
// clear/load control and a completed-instruction counter. Optional single-step debug via TIMING_STEP_EN.
module timing_seq #(
  parameter int NSTATES = 16,
  parameter int CW      = 4,
  parameter int CYC_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [CW-1:0]      load_val,
  input  logic [CW-1:0]      last_state,
`ifdef TIMING_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [CW-1:0]      t_count,
  output logic [NSTATES-1:0] t_onehot,
  output logic               done,
  output logic               load_err,
  output logic [CYC_W-1:0]   cyc_cnt
);

  localparam int            LAST_INT  = NSTATES - 1;
  localparam logic [CW-1:0] LAST_MAX  = LAST_INT[CW-1:0];
  localparam logic [CW:0]   NSTATES_W = NSTATES[CW:0];

  logic [CW-1:0]      eff_last_s;
  logic               advance_s;
  logic [CW-1:0]      t_count_nxt_s;
  logic [NSTATES-1:0] t_onehot_nxt_s;
  logic               done_nxt_s;
  logic               load_err_nxt_s;
  logic [CYC_W-1:0]   cyc_cnt_nxt_s;

  // Clamp the programmed last state to the highest implemented state.
  always_comb begin
    eff_last_s = last_state;
    if (last_state > LAST_MAX) begin
      eff_last_s = LAST_MAX;
    end else begin
      eff_last_s = last_state;
    end
  end

`ifdef TIMING_STEP_EN
  logic step_prev_r;

  // Previous step level for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_prev_r <= 1'b0;
    end else begin
      step_prev_r <= step;
    end
  end

  // In step mode only a fresh 0->1 on step advances; en is ignored.
  always_comb begin
    advance_s = 1'b0;
    if (step_mode) begin
      advance_s = step & ~step_prev_r;
    end else begin
      advance_s = en;
    end
  end
`else
  // Without debug stepping en alone advances the sequence.
  always_comb begin
    advance_s = en;
  end
`endif

  // Next-state selection with priority clr > load > advance > hold.
  always_comb begin
    t_count_nxt_s  = t_count;
    done_nxt_s     = 1'b0;
    load_err_nxt_s = 1'b0;
    if (clr) begin
      t_count_nxt_s = {CW{1'b0}};
      done_nxt_s    = 1'b1;
    end else if (load) begin
      if ({1'b0, load_val} < NSTATES_W) begin
        t_count_nxt_s = load_val;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (advance_s) begin
      // >= rather than == so a last_state lowered below the count still wraps.
      if (t_count >= eff_last_s) begin
        t_count_nxt_s = {CW{1'b0}};
        done_nxt_s    = 1'b1;
      end else begin
        t_count_nxt_s = t_count + CW'(1);
      end
    end else begin
      t_count_nxt_s = t_count;
    end
  end

  // Completion counter and one-hot decode of the next state.
  always_comb begin
    t_onehot_nxt_s = {NSTATES{1'b0}};
    if (done_nxt_s) begin
      cyc_cnt_nxt_s = cyc_cnt + CYC_W'(1);
    end else begin
      cyc_cnt_nxt_s = cyc_cnt;
    end
    for (int k = 0; k < NSTATES; k++) begin
      t_onehot_nxt_s[k] = (t_count_nxt_s == CW'(k));
    end
  end

  // Output registers; everything updates on the same edge so the bus tracks the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_count  <= {CW{1'b0}};
      t_onehot <= {{(NSTATES-1){1'b0}}, 1'b1};
      done     <= 1'b0;
      load_err <= 1'b0;
      cyc_cnt  <= {CYC_W{1'b0}};
    end else begin
      t_count  <= t_count_nxt_s;
      t_onehot <= t_onehot_nxt_s;
      done     <= done_nxt_s;
      load_err <= load_err_nxt_s;
      cyc_cnt  <= cyc_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_timing_seq.sv
// Scoreboard bench for timing_seq (NSTATES=16, CW=5, CYC_W=8); covers the TIMING_STEP_EN build when defined.
module tb_timing_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, clr, load;
  logic [4:0]  load_val, last_state;
  logic [4:0]  t_count;
  logic [15:0] t_onehot;
  logic        done, load_err;
  logic [7:0]  cyc_cnt;
`ifdef TIMING_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] cyc_e = 8'd0;

  typedef struct {
    logic [4:0] t;
    logic       d;
    logic       e;
    logic [7:0] c;
    string      nm;
  } exp_t;
  exp_t sb_q[$];
  exp_t mx;

  timing_seq #(.NSTATES(16), .CW(5), .CYC_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .last_state(last_state),
`ifdef TIMING_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .t_count(t_count), .t_onehot(t_onehot), .done(done),
    .load_err(load_err), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected post-edge state.
  task automatic tick(input logic c_i, input logic l_i, input logic [4:0] lv, input logic e_i,
                      input logic [4:0] ls, input logic [4:0] et, input logic ed, input logic ee,
                      input string nm);
    exp_t x;
    clr = c_i; load = l_i; load_val = lv; en = e_i; last_state = ls;
    if (ed) cyc_e = cyc_e + 8'd1;
    x.t = et; x.d = ed; x.e = ee; x.c = cyc_e; x.nm = nm;
    sb_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mx = sb_q.pop_front();
      chk({mx.nm, ".t_count"},  32'(t_count),  32'(mx.t));
      chk({mx.nm, ".t_onehot"}, 32'(t_onehot), 32'(16'd1 << mx.t));
      chk({mx.nm, ".done"},     32'(done),     32'(mx.d));
      chk({mx.nm, ".load_err"}, 32'(load_err), 32'(mx.e));
      chk({mx.nm, ".cyc_cnt"},  32'(cyc_cnt),  32'(mx.c));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = 5'd0; last_state = 5'd15;
    #12;
    chk("rst.t_count",  32'(t_count),  32'd0);
    chk("rst.t_onehot", 32'(t_onehot), 32'h0001);
    chk("rst.done",     32'(done),     32'd0);
    chk("rst.load_err", 32'(load_err), 32'd0);
    chk("rst.cyc_cnt",  32'(cyc_cnt),  32'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;

    // Full 16-state run, three wraps.
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'((i + 1) % 16), (i % 16) == 15, 1'b0, "run16");
    end
    chk("run16.cyc3", 32'(cyc_cnt), 32'd3);

    // last_state=13, clr coincident with natural wrap counts once.
    for (int i = 0; i < 13; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd13, 5'(i + 1), 1'b0, 1'b0, "run13");
    end
    tick(1'b1, 1'b0, 5'd0, 1'b1, 5'd13, 5'd0, 1'b1, 1'b0, "clr_wrap");
    chk("clr_wrap.onehot", 32'(t_onehot), 32'h0001);

    // Lower last_state below current count, then over-range last_state.
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'(i + 1), 1'b0, 1'b0, "to6");
    end
    tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, "lowered");
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd20, 5'((i + 1) % 16), i == 15, 1'b0, "ls20");
    end

    // Load handling and boundaries.
    tick(1'b0, 1'b1, 5'd9,  1'b1, 5'd15, 5'd9,  1'b0, 1'b0, "load9");
    chk("load9.onehot", 32'(t_onehot), 32'h0200);
    tick(1'b0, 1'b1, 5'd17, 1'b1, 5'd15, 5'd9,  1'b0, 1'b1, "load17");
    tick(1'b0, 1'b0, 5'd0,  1'b0, 5'd15, 5'd9,  1'b0, 1'b0, "idle");
    tick(1'b0, 1'b1, 5'd15, 1'b0, 5'd15, 5'd15, 1'b0, 1'b0, "load15");
    tick(1'b0, 1'b1, 5'd16, 1'b0, 5'd15, 5'd15, 1'b0, 1'b1, "load16a");
    tick(1'b0, 1'b1, 5'd16, 1'b0, 5'd15, 5'd15, 1'b0, 1'b1, "load16b");
    tick(1'b1, 1'b1, 5'd5,  1'b1, 5'd15, 5'd0,  1'b1, 1'b0, "clr_load");

    // Asynchronous reset between edges.
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'(i + 1), 1'b0, 1'b0, "to7");
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst.t_count",  32'(t_count),  32'd0);
    chk("arst.t_onehot", 32'(t_onehot), 32'h0001);
    chk("arst.cyc_cnt",  32'(cyc_cnt),  32'd0);
    chk("arst.done",     32'(done),     32'd0);
    cyc_e = 8'd0;
    @(negedge clk);
    #1;
    en = 1'b0; clr = 1'b0; load = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;

    // cyc_cnt wrap: last_state=0 completes every enabled cycle.
    for (int i = 0; i < 255; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, "ls0");
    end
    chk("cyc.max", 32'(cyc_cnt), 32'd255);
    tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd15, 5'd0, 1'b1, 1'b0, "cyc_wrap");
    chk("cyc.wrap", 32'(cyc_cnt), 32'd0);

`ifdef TIMING_STEP_EN
    // Single-step: held step advances once, each rising edge once, en ignored.
    step_mode = 1'b1;
    step = 1'b1;
    tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'd1, 1'b0, 1'b0, "step_hold");
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'd1, 1'b0, 1'b0, "step_hold");
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b0;
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'(i + 1), 1'b0, 1'b0, "step_low");
      step = 1'b1;
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'(i + 2), 1'b0, 1'b0, "step_rise");
    end
    step_mode = 1'b0;
    tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'd5, 1'b0, 1'b0, "step_off");
    tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd15, 5'd6, 1'b0, 1'b0, "step_off");
`endif

    @(negedge clk);
    #1;
    chk("sb.drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
